// File: rtl/haar_idwt_non_pipelined.sv
// rtl/haar_idwt_non_pipelined.sv - single-level inverse Haar DWT, one coefficient pair per 3-cycle slot
// Optional: define IDWT_SAT_EN to clamp reconstructed samples to the Q8.8 range instead of wrapping.

module haar_idwt_non_pipelined #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [16*(N/2)-1:0] cA_in,
  input  logic [16*(N/2)-1:0] cD_in,
  output logic [16*N-1:0]     array_out,
  output logic                busy,
  output logic                done
);

  localparam int HALF = N / 2;
  localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(HALF - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PROCESS, STORE, FINISH} state_t;

  state_t             state_q;
  logic [IW-1:0]      pair_idx_q;
  logic [16*HALF-1:0] ca_snap_q;
  logic [16*HALF-1:0] cd_snap_q;
  logic signed [15:0] ca_q;
  logic signed [15:0] cd_q;
  logic signed [24:0] ps_q;
  logic signed [24:0] pd_q;
  logic [16*N-1:0]    array_q;
  logic               busy_q;
  logic               done_q;

  logic signed [16:0] sum_d;
  logic signed [16:0] diff_d;
  logic signed [24:0] ps_d;
  logic signed [24:0] pd_d;

  // Scale back from the x181 product; the shift floors toward -inf.
  function automatic logic [15:0] to_sample(input logic signed [24:0] p);
`ifdef IDWT_SAT_EN
    logic signed [24:0] sh;
    sh = p >>> 8;
    if (sh > 25'sd32767) return 16'h7FFF;
    else if (sh < -25'sd32768) return 16'h8000;
    else return 16'(sh);
`else
    return 16'(p >>> 8);
`endif
  endfunction

  always_comb begin
    sum_d  = 17'(ca_q) + 17'(cd_q);
    diff_d = 17'(ca_q) - 17'(cd_q);
    ps_d   = 25'(sum_d) * 25'sd181;
    pd_d   = 25'(diff_d) * 25'sd181;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pair_idx_q <= '0;
      ca_snap_q  <= '0;
      cd_snap_q  <= '0;
      ca_q       <= '0;
      cd_q       <= '0;
      ps_q       <= '0;
      pd_q       <= '0;
      array_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          pair_idx_q <= '0;
          if (start) begin
            ca_snap_q <= cA_in;
            cd_snap_q <= cD_in;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          ca_q    <= ca_snap_q[16*pair_idx_q +: 16];
          cd_q    <= cd_snap_q[16*pair_idx_q +: 16];
          state_q <= PROCESS;
        end
        PROCESS: begin
          ps_q    <= ps_d;
          pd_q    <= pd_d;
          state_q <= STORE;
        end
        STORE: begin
          array_q[32*pair_idx_q +: 32] <= {to_sample(pd_q), to_sample(ps_q)};
          pair_idx_q <= pair_idx_q + IW'(1);
          state_q    <= (pair_idx_q == LAST_IDX) ? FINISH : LOAD;
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign array_out = array_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
